// File: rtl/instruction_fetch_pkg.sv
// Shared constants, types and small helpers for the instruction fetch stage.
// Imported by the fetch top and by its output skid buffer.
package instruction_fetch_pkg;

   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // BLOCKED is the single quiet cycle that follows a reset or a redirect.
   typedef enum logic [1:0] {
      FETCH_BLOCKED = 2'd0,
      FETCH_IDLE    = 2'd1,
      FETCH_WAIT    = 2'd2,
      FETCH_DISCARD = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instruction;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

   function automatic logic [31:0] next_pc(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// Output register plus one-entry skid buffer between fetch and decode.
// Flush empties both entries; a consume in the flush cycle has no effect.
module fetch_skid_buffer
   import instruction_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   input  fetch_entry_t in_entry,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [31:0]  out_pc,
   output logic [31:0]  out_instruction,
   output logic         skid_full
);

   logic         out_v_q;
   logic         skid_v_q;
   fetch_entry_t out_q;
   fetch_entry_t skid_q;
   logic         consume;

   assign consume = out_v_q & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
         out_q    <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         out_v_q  <= 1'b0;
         skid_v_q <= 1'b0;
      end else if (consume) begin
         if (skid_v_q) begin
            // Skid entry moves forward; a new arrival takes its place.
            out_q    <= skid_q;
            skid_v_q <= in_valid;
            if (in_valid) begin
               skid_q <= in_entry;
            end
         end else if (in_valid) begin
            out_q <= in_entry;
         end else begin
            out_v_q <= 1'b0;
         end
      end else if (in_valid) begin
         if (!out_v_q) begin
            out_q   <= in_entry;
            out_v_q <= 1'b1;
         end else begin
            skid_q   <= in_entry;
            skid_v_q <= 1'b1;
         end
      end
   end

   always_comb begin
      out_valid       = out_v_q;
      out_pc          = out_v_q ? out_q.pc : 32'h0;
      out_instruction = out_v_q ? out_q.instruction : INSTR_NOP;
      skid_full       = skid_v_q;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs one-at-a-time req/gnt/rvalid fetches and
// hands {pc, instruction} to decode through a registered valid/ready skid.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        valid_o,
   input  logic        ready_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o
);

   // Handshake: a transfer to decode happens on a cycle with valid_o & ready_i
   // and no redirect; payload holds while valid_o=1 and ready_i=0.

   fetch_state_e state_q;
   fetch_state_e state_d;
   logic [31:0]  pc_q;
   logic [31:0]  inflight_pc_q;
   logic         skid_full;
   logic         grant;
   logic         pending;
   logic         rsp_deliver;
   fetch_entry_t rsp_entry;

   assign grant       = imem_req_o & imem_gnt_i;
   assign pending     = (state_q == FETCH_WAIT) || (state_q == FETCH_DISCARD);
   assign rsp_deliver = imem_rvalid_i & (state_q == FETCH_WAIT) & ~redirect_i;
   assign rsp_entry   = '{pc: inflight_pc_q, instruction: imem_rdata_i};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FETCH_BLOCKED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (redirect_i) begin
         // Anything still owed by memory must be thrown away when it lands.
         if (grant || (pending && !imem_rvalid_i)) begin
            state_d = FETCH_DISCARD;
         end else begin
            state_d = FETCH_BLOCKED;
         end
      end else begin
         case (state_q)
            FETCH_BLOCKED: state_d = FETCH_IDLE;
            FETCH_IDLE:    if (grant) state_d = FETCH_WAIT;
            FETCH_WAIT:    if (imem_rvalid_i) state_d = FETCH_IDLE;
            FETCH_DISCARD: if (imem_rvalid_i) state_d = FETCH_IDLE;
            default:       state_d = FETCH_BLOCKED;
         endcase
      end
   end

   always_comb begin
      imem_req_o  = (state_q == FETCH_IDLE) && !skid_full;
      imem_addr_o = pc_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q          <= RESET_PC;
         inflight_pc_q <= 32'h0;
      end else if (redirect_i) begin
         pc_q <= align_pc(redirect_pc_i);
      end else if (grant) begin
         inflight_pc_q <= pc_q;
         pc_q          <= next_pc(pc_q);
      end
   end

   fetch_skid_buffer u_skid (
      .clk             (clk_i),
      .rst             (rst_i),
      .flush           (redirect_i),
      .in_valid        (rsp_deliver),
      .in_entry        (rsp_entry),
      .out_ready       (ready_i),
      .out_valid       (valid_o),
      .out_pc          (pc_o),
      .out_instruction (instruction_o),
      .skid_full       (skid_full)
   );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed steps followed by a randomized phase,
// checked against an in-order delivery model and a behavioural memory.
module tb_instruction_fetch;
   import instruction_fetch_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        valid_o;
   logic        ready_i;
   logic [31:0] instruction_o;
   logic [31:0] pc_o;

   int n_pass  = 0;
   int n_total = 0;
   int n_deliv = 0;

   int gnt_pct  = 100;
   int lat      = 1;
   bit rand_lat = 1'b0;
   bit hold     = 1'b0;
   bit inject   = 1'b0;

   logic [31:0] exp_q[$];
   int          pend_wait = 0;
   bit          stall_q = 1'b0;
   logic [31:0] stall_addr = '0;

   logic [31:0] exp_pc = '0;
   bit          held = 1'b0;
   logic [31:0] held_pc = '0;
   logic [31:0] held_instr = '0;

   instruction_fetch dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .instruction_o (instruction_o),
      .pc_o          (pc_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Memory: grants at most one request, answers 1..3 cycles later.
   initial begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(negedge clk_i);
         #1;
         imem_gnt_i    = 1'b0;
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
         if (rst_i) begin
            exp_q.delete();
            stall_q = 1'b0;
         end else begin
            if (stall_q) begin
               check("req_held", imem_req_o, 1);
               check("addr_held", imem_addr_o, stall_addr);
            end
            if (imem_req_o) begin
               check("single_outstanding", exp_q.size(), 0);
               check("addr_aligned", imem_addr_o[1:0], 0);
            end
            if (exp_q.size() != 0) begin
               if (pend_wait == 0) begin
                  imem_rvalid_i = 1'b1;
                  imem_rdata_i  = mem_word(exp_q.pop_front());
               end else begin
                  pend_wait--;
               end
            end
            if (imem_req_o && !hold && ($urandom_range(0, 99) < gnt_pct)) begin
               imem_gnt_i = 1'b1;
               exp_q.push_back(imem_addr_o);
               pend_wait = rand_lat ? int'($urandom_range(0, 2)) : lat - 1;
            end
            stall_q    = imem_req_o && !imem_gnt_i && !redirect_i;
            stall_addr = imem_addr_o;
         end
         if (inject) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
         end
      end
   end

   // Decode-side model: deliveries form a contiguous PC stream from the last
   // reset or redirect target, each carrying the memory word at that PC.
   initial begin
      forever begin
         @(negedge clk_i);
         #4;
         if (rst_i) begin
            exp_pc = RESET_PC_DEFAULT;
            held   = 1'b0;
         end else begin
            if (held) begin
               check("hold_valid", valid_o, 1);
               check("hold_pc", pc_o, held_pc);
               check("hold_instr", instruction_o, held_instr);
            end
            if (!valid_o) check("idle_instr_nop", instruction_o, INSTR_NOP);
            if (redirect_i) begin
               exp_pc = {redirect_pc_i[31:2], 2'b00};
            end else if (valid_o && ready_i) begin
               check("deliver_pc", pc_o, exp_pc);
               check("deliver_instr", instruction_o, mem_word(exp_pc));
               exp_pc = exp_pc + 32'd4;
               n_deliv++;
            end
            held       = valid_o && !ready_i && !redirect_i;
            held_pc    = pc_o;
            held_instr = instruction_o;
         end
      end
   end

   task automatic wait_grant(output logic [31:0] addr, output bit ok);
      ok   = 1'b0;
      addr = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         #2;
         if (imem_req_o && imem_gnt_i) begin
            addr = imem_addr_o;
            ok   = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_i);
         #2;
         if (valid_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired n_pass=%0d n_total=%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] addr;
      bit          ok;
      int          grants;
      int          base;

      rst_i = 1'b1;
      ready_i = 1'b0;
      redirect_i = 1'b0;
      redirect_pc_i = '0;
      repeat (3) @(negedge clk_i);
      #2;
      check("rst_valid", valid_o, 0);
      check("rst_req", imem_req_o, 0);
      check("rst_instr", instruction_o, INSTR_NOP);
      check("rst_pc", pc_o, 0);

      // First fetch after reset, 1-cycle memory.
      @(negedge clk_i);
      rst_i = 1'b0;
      #2;
      check("req_low_at_rst_release", imem_req_o, 0);
      @(negedge clk_i);
      #2;
      check("first_req", imem_req_o, 1);
      check("first_addr", imem_addr_o, RESET_PC_DEFAULT);
      check("first_gnt", imem_gnt_i, 1);
      @(negedge clk_i);
      #2;
      check("first_latency_valid", valid_o, 0);
      @(negedge clk_i);
      #2;
      check("first_valid", valid_o, 1);
      check("first_pc", pc_o, 0);
      check("first_instr", instruction_o, 32'h0050_0093);
      check("second_req", imem_req_o, 1);
      check("second_addr", imem_addr_o, 4);
      grants = (imem_req_o && imem_gnt_i) ? 1 : 0;

      // Decode stalls six cycles: only one more fetch fits (the skid entry).
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         #2;
         if (imem_req_o && imem_gnt_i) grants++;
         check("stall_pc", pc_o, 0);
      end
      check("stall_one_more_request", grants, 1);
      check("stall_req_low", imem_req_o, 0);
      check("stall_valid", valid_o, 1);

      // Release decode while memory withholds grant on address 8.
      @(negedge clk_i);
      ready_i = 1'b1;
      hold = 1'b1;
      #2;
      check("release_pc0", pc_o, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         inject = (i == 1);
         #2;
         check("gnt_low_req", imem_req_o, 1);
         check("gnt_low_addr", imem_addr_o, 8);
      end
      @(negedge clk_i);
      inject = 1'b0;
      hold = 1'b0;
      lat = 3;
      #2;
      check("grant_addr8", imem_addr_o, 8);
      check("grant_addr8_gnt", imem_gnt_i, 1);
      wait_grant(addr, ok);
      check("grant12_seen", ok, 1);
      check("grant12_addr", addr, 12);

      // Redirect while 12 is outstanding.
      @(negedge clk_i);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      #2;
      @(negedge clk_i);
      redirect_i = 1'b0;
      #2;
      check("redirect_valid_low", valid_o, 0);
      check("redirect_req_low", imem_req_o, 0);
      wait_grant(addr, ok);
      check("redirect_grant_seen", ok, 1);
      check("redirect_addr", addr, 32'h0000_0100);
      wait_valid(ok);
      check("redirect_valid_seen", ok, 1);
      check("redirect_first_pc", pc_o, 32'h0000_0100);
      check("redirect_first_instr", instruction_o, mem_word(32'h0000_0100));

      // Redirect coinciding with rvalid while decode is stalled.
      @(negedge clk_i);
      ready_i = 1'b0;
      lat = 1;
      wait_grant(addr, ok);
      check("coincide_grant_seen", ok, 1);
      @(negedge clk_i);
      redirect_i = 1'b1;
      redirect_pc_i = 32'h0000_2000;
      #2;
      check("coincide_pre_valid", valid_o, 1);
      @(negedge clk_i);
      redirect_i = 1'b0;
      #2;
      check("coincide_valid_dropped", valid_o, 0);
      @(negedge clk_i);
      #2;
      check("coincide_still_empty", valid_o, 0);
      check("coincide_req", imem_req_o, 1);
      check("coincide_addr", imem_addr_o, 32'h0000_2000);
      ready_i = 1'b1;
      wait_valid(ok);
      check("coincide_valid_seen", ok, 1);
      check("coincide_pc", pc_o, 32'h0000_2000);

      // Reset mid-transaction, then a stray rvalid.
      @(negedge clk_i);
      lat = 3;
      wait_grant(addr, ok);
      check("rst_mid_grant_seen", ok, 1);
      @(negedge clk_i);
      rst_i = 1'b1;
      inject = 1'b1;
      #2;
      @(negedge clk_i);
      rst_i = 1'b0;
      #2;
      check("rst_mid_valid", valid_o, 0);
      check("rst_mid_req", imem_req_o, 0);
      @(negedge clk_i);
      inject = 1'b0;
      #2;
      check("rst_mid_req_again", imem_req_o, 1);
      check("rst_mid_addr", imem_addr_o, RESET_PC_DEFAULT);
      check("rst_mid_valid_again", valid_o, 0);
      wait_valid(ok);
      check("rst_mid_valid_seen", ok, 1);
      check("rst_mid_pc", pc_o, RESET_PC_DEFAULT);
      check("rst_mid_instr", instruction_o, 32'h0050_0093);

      // PC wrap at the top of the address space.
      @(negedge clk_i);
      lat = 1;
      redirect_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFA;
      @(negedge clk_i);
      redirect_i = 1'b0;
      base = n_deliv;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (n_deliv >= base + 3) break;
      end
      check("wrap_deliveries", (n_deliv >= base + 3), 1);

      // Randomized traffic: stalls, sparse grants, variable latency, redirects.
      gnt_pct = 70;
      rand_lat = 1'b1;
      base = n_deliv;
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk_i);
         ready_i = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) begin
            redirect_i = 1'b1;
            redirect_pc_i = $urandom;
         end else begin
            redirect_i = 1'b0;
         end
      end
      @(negedge clk_i);
      redirect_i = 1'b0;
      ready_i = 1'b1;
      gnt_pct = 100;
      repeat (20) @(negedge clk_i);
      check("random_progress", ((n_deliv - base) > 100), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of decode; the instruction word it delivers feeds the immediate generator, opcode decode and register-file address logic.
- Owns the PC and issues one 32-bit request at a time to instruction memory over a req/gnt/rvalid handshake.
- Delivers {pc, instruction} to decode through a valid/ready interface with a one-entry skid buffer.
- Accepts a redirect (branch, jump or trap target) from execute; redirect flushes the stage.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch byte address, word aligned.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  instruction word.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  32  new fetch address.
- valid_o  out  1  instruction_o and pc_o are valid.
- ready_i  in  1  decode accepts this cycle.
- instruction_o  out  32  fetched instruction; `INSTR_NOP when valid_o=0.
- pc_o  out  32  address of instruction_o.

Behaviour:
- Reset (any cycle, including mid-transaction):
  - pc_q=RESET_PC; outstanding=0; discard=0.
  - Output register and skid buffer empty.
  - valid_o=0, imem_req_o=0, instruction_o=`INSTR_NOP, pc_o=0.
  - Any rvalid that arrives after reset while outstanding=0 is ignored.
- Memory handshake:
  - imem_req_o=1 iff outstanding=0, skid buffer empty, and redirect_i=0 in the previous cycle's update.
  - imem_addr_o=pc_q; req and addr are held stable until gnt, except when a redirect occurs.
  - On req&gnt: outstanding<=1, inflight_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
  - Memory asserts rvalid no earlier than the cycle after gnt. At most one request is outstanding.
  - First request issues the cycle after reset deasserts, so fetch-to-valid_o latency is at least 2 cycles.
- Response:
  - On rvalid with outstanding=1: outstanding<=0.
  - If discard=1: drop the data and clear discard.
  - Otherwise, if the output register is empty or being consumed (valid_o&ready_i), load {inflight_pc, rdata} into it.
  - Otherwise load it into the skid buffer.
- Decode side:
  - valid_o is registered; decode must not assume a combinational path from rvalid.
  - On valid_o&ready_i, the output register takes the skid entry if present, else becomes empty.
  - instruction_o/pc_o hold stable while valid_o=1 and ready_i=0.
- Redirect (priority over all else except reset):
  - pc_q<=redirect_pc_i with bits [1:0] forced to 0.
  - Output register and skid buffer are cleared, so valid_o=0 the next cycle.
  - An ungranted request is abandoned; the address may change.
  - If a request is outstanding, or is granted in the redirect cycle, set discard=1.
  - An rvalid coinciding with redirect is dropped.
  - A consume (ready_i) in the redirect cycle has no effect.
- Throughput: one instruction per 2 cycles with a 1-cycle memory. Pipelining is out of scope.

Decomposition:
- defines.v gains `INSTR_NOP (32'h0000_0013) and `RESET_PC_DEFAULT.
- Sub-module fetch_skid_buffer holds the output register and skid entry with a valid/ready interface and flush input.
- instruction_fetch holds the PC, the outstanding/discard flags and the memory handshake.

Test Plan:
- Reset, memory with gnt=1 and 1-cycle rvalid returning 32'h00500093 at addr 0 -> req at cycle 1, valid_o=1 with pc_o=0 and instruction_o=32'h00500093; next fetch addr 4.
- ready_i=0 for 6 cycles -> exactly one more request issues (into the skid buffer), then req stays low; releasing ready_i delivers pc 0,4,8 in order with no loss or duplication.
- gnt held low 3 cycles with addr 8 -> imem_req_o and imem_addr_o=8 stable throughout; pc_q advances only on gnt.
- Redirect to 32'h0000_0103 while a request to 12 is outstanding -> response for 12 is dropped; next request addr=32'h100; first valid_o has pc_o=32'h100.
- Redirect in the same cycle as rvalid and valid_o&ready_i=0 -> both output and response are dropped; valid_o=0 the next cycle.
- rst_i asserted while a request is outstanding, then a late rvalid -> ignored; first request after reset addr=RESET_PC.
